// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI peripheral: frame width, default fill byte
// and the frame state encoding.
package spi_pkg;

  localparam int SPI_WORD_BITS = 8;
  localparam int SPI_COUNT_BITS = $clog2(SPI_WORD_BITS);
  localparam logic [SPI_WORD_BITS-1:0] DEFAULT_FILL_BYTE = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// sync_edge
// Brings one asynchronous input into the clock domain through STAGES
// flip-flops, then compares against one extra delay register to produce
// single-cycle edge strobes.
//   clock     in   system clock
//   reset     in   synchronous, active-high
//   async_in  in   asynchronous input pin
//   level     out  synchronized level
//   rise      out  one-cycle strobe on a synchronized 0->1 transition
//   fall      out  one-cycle strobe on a synchronized 1->0 transition
module sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stage_reg;
  logic              delay_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_reg <= {STAGES{RESET_VALUE}};
      delay_reg <= RESET_VALUE;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], async_in};
      delay_reg <= stage_reg[STAGES-1];
    end
  end

  assign level = stage_reg[STAGES-1];
  assign rise  = level & ~delay_reg;
  assign fall  = ~level & delay_reg;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral
// SPI mode 0 target, MSB first, 8-bit frames. External pins are synchronized
// into the clock domain and edge-detected; all shifting happens on those
// synchronized edges.
//   clock, reset           system clock, synchronous active-high reset
//   rx_data, rx_valid      last complete received byte and its one-cycle strobe
//   tx_data, tx_valid,     one-deep transmit holding register (write when
//   tx_ready               tx_valid && tx_ready)
//   tx_underrun            one-cycle strobe when FILL_BYTE replaced an empty holding register
//   spi_clk, spi_cs_n,     asynchronous SPI inputs
//   spi_copi
//   spi_cipo, spi_cipo_oe  serial output and its pad enable
module spi_peripheral
  import spi_pkg::*;
#(
  parameter logic [SPI_WORD_BITS-1:0] FILL_BYTE   = DEFAULT_FILL_BYTE,
  parameter int                       SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [SPI_WORD_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic [SPI_WORD_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx_underrun,
  input  logic                     spi_clk,
  input  logic                     spi_cs_n,
  input  logic                     spi_copi,
  output logic                     spi_cipo,
  output logic                     spi_cipo_oe
);

  localparam int MSB = SPI_WORD_BITS - 1;
  localparam logic [SPI_COUNT_BITS-1:0] LAST_BIT = SPI_COUNT_BITS'(MSB);

  logic clk_level, clk_rise, clk_fall;
  logic cs_level, cs_rise, cs_fall;

  // cs_n resets low so a chip select already asserted at reset release is
  // not mistaken for a new frame start.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) clk_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(spi_clk),
    .level   (clk_level),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) cs_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(spi_cs_n),
    .level   (cs_level),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  // copi uses the same depth as spi_clk, so at a synchronized clock rise the
  // synchronized data bit is the one present at the pin's rising edge.
  logic [SYNC_STAGES-1:0] copi_sync_reg;
  logic                   copi_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      copi_sync_reg <= '0;
    end else begin
      copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], spi_copi};
    end
  end

  assign copi_level = copi_sync_reg[SYNC_STAGES-1];

  spi_state_t                state_reg, state_next;
  logic [SPI_COUNT_BITS-1:0] count_reg, count_next;
  logic [MSB:0]              rx_shift_reg, rx_shift_next;
  logic [MSB:0]              rx_data_reg, rx_data_next;
  logic                      rx_valid_reg, rx_valid_next;
  logic [MSB:0]              tx_shift_reg, tx_shift_next;
  logic [MSB:0]              tx_hold_reg, tx_hold_next;
  logic                      tx_full_reg, tx_full_next;
  logic                      underrun_reg, underrun_next;
  logic                      cipo_reg, cipo_next;
  logic                      cipo_oe_reg, cipo_oe_next;
  logic [MSB:0]              load_byte;
  logic [MSB:0]              rx_completed;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      tx_shift_reg <= '0;
      tx_hold_reg  <= '0;
      tx_full_reg  <= 1'b0;
      underrun_reg <= 1'b0;
      cipo_reg     <= 1'b0;
      cipo_oe_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      tx_shift_reg <= tx_shift_next;
      tx_hold_reg  <= tx_hold_next;
      tx_full_reg  <= tx_full_next;
      underrun_reg <= underrun_next;
      cipo_reg     <= cipo_next;
      cipo_oe_reg  <= cipo_oe_next;
    end
  end

  // Byte loaded at a byte boundary: the holding register if it is full,
  // otherwise the fill byte.
  assign load_byte    = tx_full_reg ? tx_hold_reg : FILL_BYTE;
  assign rx_completed = {rx_shift_reg[MSB-1:0], copi_level};

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    tx_shift_next = tx_shift_reg;
    tx_hold_next  = tx_hold_reg;
    tx_full_next  = tx_full_reg;
    underrun_next = 1'b0;
    cipo_next     = cipo_reg;
    cipo_oe_next  = cipo_oe_reg;

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next    = ACTIVE;
          count_next    = '0;
          tx_shift_next = load_byte;
          cipo_next     = load_byte[MSB];
          cipo_oe_next  = 1'b1;
          tx_full_next  = 1'b0;
          underrun_next = ~tx_full_reg;
        end
      end
      ACTIVE: begin
        // Deselect wins over any clock edge seen in the same cycle.
        if (cs_rise) begin
          state_next   = IDLE;
          count_next   = '0;
          cipo_next    = 1'b0;
          cipo_oe_next = 1'b0;
        end else if (!cs_level && clk_rise && clk_level) begin
          rx_shift_next = rx_completed;
          count_next    = count_reg + 1'b1;
          if (count_reg == LAST_BIT) begin
            rx_data_next  = rx_completed;
            rx_valid_next = 1'b1;
          end
        end else if (!cs_level && clk_fall) begin
          if (count_reg == '0) begin
            tx_shift_next = load_byte;
            cipo_next     = load_byte[MSB];
            tx_full_next  = 1'b0;
            underrun_next = ~tx_full_reg;
          end else begin
            tx_shift_next = {tx_shift_reg[MSB-1:0], 1'b0};
            cipo_next     = tx_shift_reg[MSB-1];
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A write needs an empty register, so it can never collide with a
    // consume; a load from empty in this same cycle has already used FILL_BYTE.
    if (tx_valid && !tx_full_reg) begin
      tx_hold_next = tx_data;
      tx_full_next = 1'b1;
    end
  end

  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_ready    = ~tx_full_reg;
  assign tx_underrun = underrun_reg;
  assign spi_cipo    = cipo_reg;
  assign spi_cipo_oe = cipo_oe_reg;

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral
// Drives SPI mode 0 frames into spi_peripheral and checks received bytes,
// shifted-out bytes, holding-register handshake and underrun strobes.
module tb_spi_peripheral;
  localparam int H = 8;  // spi_clk half period in system clocks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_underrun;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_copi = 1'b0;
  logic       spi_cipo;
  logic       spi_cipo_oe;

  spi_peripheral dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .spi_clk    (spi_clk),
    .spi_cs_n   (spi_cs_n),
    .spi_copi   (spi_copi),
    .spi_cipo   (spi_cipo),
    .spi_cipo_oe(spi_cipo_oe)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int underrun_cnt = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] cipo_exp_q[$];
  logic [7:0] send_q[$];
  logic first_ready, first_oe;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Scoreboard side: every rx_valid pops one expected byte.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        checks++;
        if (rx_exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected got=%h expected=none", rx_data);
        end else begin
          logic [7:0] exp;
          exp = rx_exp_q.pop_front();
          if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_byte got=%h expected=%h", rx_data, exp);
          end else begin
            $display("ok   rx_byte = %h", rx_data);
          end
        end
      end
      if (tx_underrun) underrun_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic write_tx(input logic [7:0] b);
    int waited = 0;
    while (!tx_ready && waited < 400) begin
      tick(1);
      waited++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_wait got=0 expected=1");
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Controller: shifts send_q out MSB first for nbits bits; captures cipo at
  // each rising pin edge and compares each full byte against cipo_exp_q.
  // The last falling edge coincides with cs_n rising.
  task automatic run_frame(input int nbits);
    logic [7:0] cap = 8'h00;
    logic [7:0] cur;
    spi_cs_n = 1'b0;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      cur = send_q[i/8];
      spi_clk  = 1'b0;
      spi_copi = cur[7 - (i % 8)];
      tick(H);
      if (i == 0) begin
        first_ready = tx_ready;
        first_oe    = spi_cipo_oe;
      end
      cap = {cap[6:0], spi_cipo};
      if (i % 8 == 7) rx_exp_q.push_back(cur);
      spi_clk = 1'b1;
      tick(H);
      if (i % 8 == 7) begin
        if (cipo_exp_q.size() == 0) begin
          check("cipo_no_expectation", 32'(cap), 32'h1FF);
        end else begin
          check("cipo_byte", 32'(cap), 32'(cipo_exp_q.pop_front()));
        end
      end
    end
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_copi = 1'b0;
    tick(H);
    send_q.delete();
  endtask

  typedef struct {
    logic       preload;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] exp_cipo;
    int         exp_underrun;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int u0;
    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1};
    vecs[2] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 0};
    vecs[3] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1};

    tick(4);
    reset = 1'b0;
    tick(2);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_tx_ready", 32'(tx_ready), 32'h1);
    check("reset_tx_underrun", 32'(tx_underrun), 32'h0);
    check("reset_cipo", 32'(spi_cipo), 32'h0);
    check("reset_cipo_oe", 32'(spi_cipo_oe), 32'h0);
    tick(H);

    // Table-driven single-byte frames.
    for (int v = 0; v < 4; v++) begin
      u0 = underrun_cnt;
      if (vecs[v].preload) write_tx(vecs[v].tx);
      send_q.push_back(vecs[v].rx);
      cipo_exp_q.push_back(vecs[v].exp_cipo);
      run_frame(8);
      check("vec_ready_after_cs", 32'(first_ready), 32'h1);
      check("vec_oe_in_frame", 32'(first_oe), 32'h1);
      check("vec_oe_after_frame", 32'(spi_cipo_oe), 32'h0);
      check("vec_underruns", 32'(underrun_cnt - u0), 32'(vecs[v].exp_underrun));
      check("vec_rx_data", 32'(rx_data), 32'(vecs[v].rx));
      check("vec_rx_pending", 32'(rx_exp_q.size()), 32'h0);
    end

    // Two bytes in one frame; second tx byte written during the first byte.
    u0 = underrun_cnt;
    write_tx(8'h12);
    send_q.push_back(8'h01);
    send_q.push_back(8'h80);
    cipo_exp_q.push_back(8'h12);
    cipo_exp_q.push_back(8'h34);
    fork
      run_frame(16);
      begin
        tick(4 * H);
        write_tx(8'h34);
      end
    join
    check("two_byte_underruns", 32'(underrun_cnt - u0), 32'h0);
    check("two_byte_rx_data", 32'(rx_data), 32'h80);
    check("two_byte_rx_pending", 32'(rx_exp_q.size()), 32'h0);

    // Partial frame (5 bits) discarded, then a fresh frame.
    u0 = underrun_cnt;
    send_q.push_back(8'hF0);
    run_frame(5);
    check("partial_oe_between", 32'(spi_cipo_oe), 32'h0);
    check("partial_no_rx", 32'(rx_data), 32'h80);
    send_q.push_back(8'hC3);
    cipo_exp_q.push_back(8'hFF);
    run_frame(8);
    check("partial_rx_data", 32'(rx_data), 32'hC3);
    check("partial_underruns", 32'(underrun_cnt - u0), 32'h2);

    // tx_valid held high: only the first byte is taken until a frame consumes it.
    u0 = underrun_cnt;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    tick(1);
    check("held_ready_after_write", 32'(tx_ready), 32'h0);
    tx_data = 8'h66;
    tick(10);
    check("held_ready_blocked", 32'(tx_ready), 32'h0);
    send_q.push_back(8'h0F);
    cipo_exp_q.push_back(8'h55);
    run_frame(8);
    check("held_second_accepted", 32'(tx_ready), 32'h0);
    tx_valid = 1'b0;
    send_q.push_back(8'hF0);
    cipo_exp_q.push_back(8'h66);
    run_frame(8);
    check("held_underruns", 32'(underrun_cnt - u0), 32'h0);
    check("held_rx_data", 32'(rx_data), 32'hF0);

    // Reset mid-frame with cs_n low.
    write_tx(8'hAA);
    spi_cs_n = 1'b0;
    tick(H);
    write_tx(8'hBB);
    for (int k = 0; k < 3; k++) begin
      spi_copi = 1'b1;
      spi_clk  = 1'b1;
      tick(H);
      spi_clk = 1'b0;
      tick(H);
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_tx_ready", 32'(tx_ready), 32'h1);
    check("midreset_tx_underrun", 32'(tx_underrun), 32'h0);
    check("midreset_cipo", 32'(spi_cipo), 32'h0);
    check("midreset_cipo_oe", 32'(spi_cipo_oe), 32'h0);
    for (int k = 0; k < 8; k++) begin
      spi_clk = 1'b1;
      tick(H);
      spi_clk = 1'b0;
      tick(H);
    end
    check("midreset_ignored_oe", 32'(spi_cipo_oe), 32'h0);
    check("midreset_ignored_rx", 32'(rx_data), 32'h00);
    spi_cs_n = 1'b1;
    spi_copi = 1'b0;
    tick(H);
    u0 = underrun_cnt;
    send_q.push_back(8'h96);
    cipo_exp_q.push_back(8'hFF);
    run_frame(8);
    check("postreset_rx_data", 32'(rx_data), 32'h96);
    check("postreset_underruns", 32'(underrun_cnt - u0), 32'h1);

    check("final_rx_pending", 32'(rx_exp_q.size()), 32'h0);
    check("final_cipo_pending", 32'(cipo_exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI target (peripheral) for mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. Samples externally driven spi_clk / spi_cs_n / spi_copi through synchronizers into the system clock domain and drives spi_cipo. Exposes a byte-wide receive strobe and a one-deep transmit holding register to internal logic. It is the counterpart of the team's SPI controller and is used wherever the design is on the far side of an SPI link.

## Interface
- FILL_BYTE, 8'hFF, byte shifted out when no transmit byte is pending at a byte boundary
- SYNC_STAGES, 2, flip-flop stages on each external input (minimum 2)

- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- rx_data  out  8  last fully received byte; holds until next complete byte
- rx_valid  out  1  one-cycle pulse, rx_data updated this cycle
- tx_data  in  8  next byte to transmit
- tx_valid  in  1  tx_data valid; accepted when tx_valid && tx_ready
- tx_ready  out  1  holding register empty
- tx_underrun  out  1  one-cycle pulse, FILL_BYTE substituted at a byte boundary
- spi_clk  in  1  external serial clock, asynchronous
- spi_cs_n  in  1  external chip select, active-low, asynchronous
- spi_copi  in  1  controller-out data, asynchronous
- spi_cipo  out  1  controller-in data
- spi_cipo_oe  out  1  output enable for spi_cipo pad; high only while selected

## Operation
- Reset values: rx_data 8'h00, rx_valid 0, tx_ready 1, tx_underrun 0, spi_cipo 0, spi_cipo_oe 0, state IDLE, bit counter 0. Synchronizers reset to spi_clk=0, spi_cs_n=0 so a low cs at reset release does not register as a frame start.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE on synchronized cs_n falling edge: load shift-out register from holding register (tx_ready -> 1) or FILL_BYTE if empty (tx_underrun pulse); spi_cipo = bit 7; spi_cipo_oe = 1; bit counter = 0.
- ACTIVE, synchronized spi_clk rising: shift copi into rx shift register LSB; counter += 1 (3-bit, wraps 7 -> 0). On wrap: rx_data <= completed byte, rx_valid pulse next cycle-edge (same register update).
- ACTIVE, synchronized spi_clk falling: if counter == 0 (byte boundary) load next byte as above (holding or FILL_BYTE + tx_underrun) and drive its bit 7; else shift out next bit.
- ACTIVE -> IDLE on synchronized cs_n rising edge, checked before clock edges in the same cycle: partial rx byte discarded (no rx_valid), partial tx byte discarded, counter = 0, spi_cipo = 0, spi_cipo_oe = 0. Holding register content is kept.
- Holding register: write when tx_valid && tx_ready; tx_ready = 0 until consumed. Consume and write never coincide (write requires empty); a load from empty uses FILL_BYTE even if tx_valid is high that cycle.
- Reset mid-frame: return to reset values; no frame starts until a new cs_n falling edge is observed.

## Timing
- External edge detected SYNC_STAGES+1 clocks after the pin transition (3 at default).
- spi_cipo update: ≤ SYNC_STAGES+2 clocks after spi_clk falling pin edge or cs_n falling pin edge.
- rx_valid: SYNC_STAGES+2 clocks after the 8th spi_clk rising pin edge.
- Link constraints (documented, not checked): spi_clk high and low time ≥ 2*(SYNC_STAGES+2) clocks; cs_n assert to first spi_clk rise ≥ same; cs_n high time ≥ SYNC_STAGES+2 clocks.
- Internal side must write the next tx byte within 8 spi_clk periods of tx_ready rising to avoid underrun.

## Structure
- Shared package spi_pkg: SPI_WORD_BITS = 8, default fill byte, state encoding IDLE/ACTIVE.
- One sub-module: sync_edge (SYNC_STAGES flip-flops plus one delay register; outputs level, rise, fall; reset value parameter). Instantiated for spi_clk and spi_cs_n; spi_copi uses the same stage count so it stays aligned with spi_clk.

## Test plan
- Load tx 8'hA5, controller sends 8'h3C at half-period 8 clocks -> one rx_valid with rx_data 8'h3C; spi_cipo sampled on rising edges = 1,0,1,0,0,1,0,1; tx_ready high after cs_n falls.
- No tx loaded, frame of 8'h00 -> spi_cipo shifts 8'hFF, tx_underrun one pulse at frame start, rx_data 8'h00.
- Single cs frame of 8'h01, 8'h80; tx 8'h12 preloaded, 8'h34 written during first byte -> rx_valid twice (8'h01 then 8'h80), spi_cipo 8'h12 then 8'h34, no underrun.
- cs_n deasserted after 5 bits, then a fresh frame 8'hC3 -> no rx_valid for the partial, rx_data 8'hC3 after second frame, spi_cipo_oe 0 between frames.
- tx_valid held high with 8'h55 then 8'h66 -> only 8'h55 accepted, tx_ready 0 until frame start, then 8'h66 accepted.
- reset asserted mid-frame with cs_n low -> all outputs at reset values; remaining spi_clk edges ignored; next frame after cs_n high/low receives correctly.
